// File: rtl/disp_pkg.sv
// Shared constants and the leading-zero blanking helper for the multiplexed
// seven-segment display path.
package disp_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 16;

    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Bit i set when digit i is a leading zero. Digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] shadow,
        input int                             digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i > 0; i--) begin
            if (i < digits) begin
                zero_above = zero_above && (shadow[NIBBLE_W*i +: NIBBLE_W] == '0);
                mask[i]    = zero_above;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/digit_scanner_scan_tick.sv
// Slot and digit counters for the display scan; flags the dead-time window,
// the last cycle of each slot and the last cycle of each frame.
module scan_tick
    import disp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 2,
    parameter int CNT_W  = $clog2(DIV),
    parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             dead,
    output logic             dead_nxt,
    output logic             slot_end,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    if (DIV < 2) begin : g_div_check
        $fatal(1, "scan_tick: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;

    // NOTE: every output gets a value before any branch, so no latch can be inferred.
    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        idx_nxt   = idx;
        if (slot_end) begin
            idx_nxt = frame_end ? '0 : idx + 1'b1;
        end
        dead      = (cnt < DEAD_C);
        dead_nxt  = (cnt_nxt < DEAD_C);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexes a DIGITS-wide hex value onto one shared seven-segment decoder,
// with frame-aligned double buffering, leading-zero blanking and anode dead time.
module digit_scanner
    import disp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [NIBBLE_W*DIGITS-1:0]   value,
    input  logic                         blank_lz,
    output logic [NIBBLE_W-1:0]          nibble,
    output logic [DIGITS-1:0]            an,
    output logic                         frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = NIBBLE_W * DIGITS;

    if (DEAD < 0 || DEAD >= DIV) begin : g_dead_check
        $fatal(1, "digit_scanner: DEAD must satisfy 0 <= DEAD < DIV");
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_digits_check
        $fatal(1, "digit_scanner: DIGITS out of range");
    end

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  dead;
    logic                  dead_nxt;
    logic                  slot_end;
    logic                  frame_end;
    logic [VAL_W-1:0]      shadow;
    logic [VAL_W-1:0]      shadow_nxt;
    logic [VAL_W-1:0]      pend;
    logic [VAL_W-1:0]      pend_nxt;
    logic                  pend_v;
    logic                  pend_v_nxt;
    logic [MAX_DIGITS-1:0] blank;
    logic [NIBBLE_W-1:0]   nibble_nxt;
    logic [DIGITS-1:0]     an_nxt;

    scan_tick #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .DEAD   (DEAD),
        .IDX_W  (IDX_W)
    ) u_scan_tick (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .dead      (dead),
        .dead_nxt  (dead_nxt),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    // Outputs are registered from next-state so they line up with the live cnt/idx.
    always_comb begin
        shadow_nxt = shadow;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        if (frame_end) begin
            if (load) begin
                shadow_nxt = value;
            end else if (pend_v) begin
                shadow_nxt = pend;
            end
            pend_v_nxt = 1'b0;
        end else if (load) begin
            pend_nxt   = value;
            pend_v_nxt = 1'b1;
        end

        idx_nxt    = frame_end ? '0 : (slot_end ? idx + 1'b1 : idx);
        blank      = lz_mask((NIBBLE_W*MAX_DIGITS)'(shadow_nxt), DIGITS) & {MAX_DIGITS{blank_lz}};
        nibble_nxt = shadow_nxt[NIBBLE_W*idx_nxt +: NIBBLE_W];
        an_nxt     = AN_OFF[DIGITS-1:0];
        if (!dead_nxt && !blank[idx_nxt]) begin
            an_nxt[idx_nxt] = 1'b0;
        end
    end

    // NOTE: the buffers are plain registers, so they are reset to give a clean 0 after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            nibble <= '0;
            an     <= AN_OFF[DIGITS-1:0];
        end else begin
            shadow <= shadow_nxt;
            pend   <= pend_nxt;
            pend_v <= pend_v_nxt;
            nibble <= nibble_nxt;
            an     <= an_nxt;
        end
    end

    assign frame_done = frame_end;

    a_dead_all_off: assert property (@(posedge clk) disable iff (rst)
        dead |-> (an == AN_OFF[DIGITS-1:0]));
    a_one_anode: assert property (@(posedge clk) disable iff (rst)
        $countones(~an) <= 1);

endmodule

// File: tb/tb_digit_scanner.sv
// Directed, table-driven bench for digit_scanner with DIGITS=4, DIV=8, DEAD=2.
module tb_digit_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int DEAD   = 2;
    localparam int FRAME  = DIGITS * DIV;
    localparam logic [15:0] IDLE_VALUE = 16'h9999;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] nib;
        logic       fd;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } ld_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        load     = 1'b0;
    logic [15:0] value    = IDLE_VALUE;
    logic        blank_lz = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    vec_t       vecs[$];
    ld_t        loads[$];
    bit         bad_en  = 1'b0;
    logic [3:0] bad_nib = 4'h0;
    bit         chk_en  = 1'b0;
    int         cyc     = 0;

    digit_scanner #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .DEAD   (DEAD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .nibble     (nibble),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent cycle count since reset drives the continuous checks.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("one_anode_max", 32'($countones(~an) <= 1), 1);
            check("frame_done_phase", frame_done, 32'(cyc % FRAME == FRAME - 1));
            if (cyc % DIV < DEAD) check("dead_time_an", an, 4'hF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        load = 1'b0;
        repeat (3) tick();
        check("reset_an", an, 4'hF);
        check("reset_nibble", nibble, 4'h0);
        check("reset_frame_done", frame_done, 1'b0);
        rst = 1'b0;
    endtask

    function automatic void v(input int c, input logic [3:0] a, input logic [3:0] n, input logic f);
        vecs.push_back(vec_t'{c, a, n, f});
    endfunction

    function automatic void ld(input int c, input logic [15:0] val);
        loads.push_back(ld_t'{c, val});
    endfunction

    function automatic void clear_tables();
        vecs.delete();
        loads.delete();
        bad_en = 1'b0;
    endfunction

    // Cycle 0 is the first cycle after the last reset edge.
    task automatic run(input int last);
        for (int c = 0; c <= last; c++) begin
            foreach (vecs[k]) begin
                if (vecs[k].cyc == c) begin
                    check($sformatf("c%0d_an", c), an, vecs[k].an);
                    check($sformatf("c%0d_nibble", c), nibble, vecs[k].nib);
                    check($sformatf("c%0d_frame_done", c), frame_done, vecs[k].fd);
                end
            end
            if (bad_en) check($sformatf("c%0d_stale_absent", c), 32'(nibble != bad_nib), 1);
            load  = 1'b0;
            value = IDLE_VALUE;
            foreach (loads[k]) begin
                if (loads[k].cyc == c) begin
                    load  = 1'b1;
                    value = loads[k].val;
                end
            end
            tick();
        end
        load  = 1'b0;
        value = IDLE_VALUE;
    endtask

    initial begin
        // Reset, scan timing, and a mid-frame load shown one frame later.
        apply_reset();
        chk_en = 1'b1;
        clear_tables();
        ld(5, 16'h1234);
        v(0,  4'b1111, 4'h0, 1'b0);
        v(2,  4'b1110, 4'h0, 1'b0);
        v(7,  4'b1110, 4'h0, 1'b0);
        v(8,  4'b1111, 4'h0, 1'b0);
        v(10, 4'b1101, 4'h0, 1'b0);
        v(15, 4'b1101, 4'h0, 1'b0);
        v(18, 4'b1011, 4'h0, 1'b0);
        v(26, 4'b0111, 4'h0, 1'b0);
        v(31, 4'b0111, 4'h0, 1'b1);
        v(32, 4'b1111, 4'h4, 1'b0);
        v(34, 4'b1110, 4'h4, 1'b0);
        v(42, 4'b1101, 4'h3, 1'b0);
        v(50, 4'b1011, 4'h2, 1'b0);
        v(58, 4'b0111, 4'h1, 1'b0);
        v(63, 4'b0111, 4'h1, 1'b1);
        run(63);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        apply_reset();
        clear_tables();
        ld(1, 16'h0070);
        ld(40, 16'h0000);
        v(2,  4'b1110, 4'h0, 1'b0);
        v(10, 4'b1111, 4'h0, 1'b0);
        v(18, 4'b1111, 4'h0, 1'b0);
        v(26, 4'b1111, 4'h0, 1'b0);
        v(34, 4'b1110, 4'h0, 1'b0);
        v(42, 4'b1101, 4'h7, 1'b0);
        v(50, 4'b1111, 4'h0, 1'b0);
        v(58, 4'b1111, 4'h0, 1'b0);
        v(66, 4'b1110, 4'h0, 1'b0);
        v(74, 4'b1111, 4'h0, 1'b0);
        v(82, 4'b1111, 4'h0, 1'b0);
        v(90, 4'b1111, 4'h0, 1'b0);
        run(95);
        blank_lz = 1'b0;

        // Second load in a frame overwrites the pending value.
        apply_reset();
        clear_tables();
        bad_en  = 1'b1;
        bad_nib = 4'hA;
        ld(3,  16'hAAAA);
        ld(20, 16'h5555);
        v(34, 4'b1110, 4'h5, 1'b0);
        v(42, 4'b1101, 4'h5, 1'b0);
        v(50, 4'b1011, 4'h5, 1'b0);
        v(58, 4'b0111, 4'h5, 1'b0);
        run(63);

        // Load on the frame_done cycle wins over the pending value and clears it.
        apply_reset();
        clear_tables();
        ld(10, 16'h1111);
        ld(31, 16'hBEEF);
        v(31, 4'b0111, 4'h0, 1'b1);
        v(32, 4'b1111, 4'hF, 1'b0);
        v(34, 4'b1110, 4'hF, 1'b0);
        v(42, 4'b1101, 4'hE, 1'b0);
        v(50, 4'b1011, 4'hE, 1'b0);
        v(58, 4'b0111, 4'hB, 1'b0);
        v(66, 4'b1110, 4'hF, 1'b0);
        v(90, 4'b0111, 4'hB, 1'b0);
        run(95);

        // Reset mid-slot 2 discards the pending value and overrides a coincident load.
        apply_reset();
        clear_tables();
        ld(3, 16'h1234);
        run(19);
        rst   = 1'b1;
        load  = 1'b1;
        value = 16'hFFFF;
        tick();
        rst   = 1'b0;
        load  = 1'b0;
        value = IDLE_VALUE;
        check("midreset_an", an, 4'hF);
        check("midreset_nibble", nibble, 4'h0);
        check("midreset_frame_done", frame_done, 1'b0);
        clear_tables();
        v(2,  4'b1110, 4'h0, 1'b0);
        v(10, 4'b1101, 4'h0, 1'b0);
        v(34, 4'b1110, 4'h0, 1'b0);
        v(42, 4'b1101, 4'h0, 1'b0);
        v(58, 4'b0111, 4'h0, 1'b0);
        run(63);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
